// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared ripple-carry adder with a single result register.
// Latency: result registered 1 cycle after grant; one operation per cycle while out_ready is high.
// Backpressure: while a result is held and out_ready is low, no grant is issued and outputs hold.
module adder_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a,
  input  logic [NREQ*WIDTH-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic                  out_carry,
  output logic [IDW-1:0]        out_id
);

  logic [IDW-1:0]   r_ptr;
  logic             r_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDW-1:0]   r_id;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_cand;
  logic             w_accept;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_c;

  // Pick the first requesting index at or above ptr, wrapping to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Reset blocks acceptance so nothing granted during reset is ever consumed.
  assign w_accept  = !reset && w_found && (!r_vld || out_ready);
  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // One-hot grant to the winner, only in accepting cycles; also steers the operand mux.
  always_comb begin
    gnt   = '0;
    w_opa = '0;
    w_opb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        gnt[i] = w_accept;
        w_opa  = a[i*WIDTH +: WIDTH];
        w_opb  = b[i*WIDTH +: WIDTH];
      end
    end
  end

  // The single shared ripple-carry adder, carry-in 0, carry rippled LSB to MSB.
  always_comb begin
    w_sum = '0;
    w_c   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = w_opa[i] ^ w_opb[i] ^ w_c;
      w_c      = (w_opa[i] & w_opb[i]) | (w_c & (w_opa[i] ^ w_opb[i]));
    end
    w_carry = w_c;
  end

  // Result register and round-robin pointer: load on accept, drop valid on a pure drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_vld   <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_ptr_nxt;
      r_vld   <= 1'b1;
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_id    <= w_win;
    end else if (out_ready) begin
      r_vld   <= 1'b0;
    end
  end

  assign out_valid = r_vld;
  assign out_sum   = r_sum;
  assign out_carry = r_carry;
  assign out_id    = r_id;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and sum width in bits.
REQ-002 Parameter NREQ, default 4, sets the number of requesters; the legal range is 2..16.
REQ-003 Derived IDW = max(1, clog2(NREQ)), the width of the requester index.
REQ-004 Port `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 Port `req`, input, NREQ bits: per-requester request; bit i high means operands i are valid.
REQ-007 Port `a`, input, NREQ*WIDTH bits: operand A for requester i is slice [i*WIDTH +: WIDTH].
REQ-008 Port `b`, input, NREQ*WIDTH bits: operand B for requester i is slice [i*WIDTH +: WIDTH].
REQ-009 Port `gnt`, output, NREQ bits: one-hot or zero; gnt[i] high means requester i's operands are consumed this cycle.
REQ-010 Port `out_valid`, output, 1 bit: the result register holds an undelivered result.
REQ-011 Port `out_ready`, input, 1 bit: the consumer accepts the result this cycle.
REQ-012 Port `out_sum`, output, WIDTH bits: registered sum.
REQ-013 Port `out_carry`, output, 1 bit: registered carry-out of the MSB.
REQ-014 Port `out_id`, output, IDW bits: index of the requester that owns the result.

Function
REQ-015 The block SHALL contain exactly one WIDTH-bit ripple-carry adder with carry-in 0, shared among all requesters.
REQ-016 Arithmetic: {out_carry, out_sum} = a_i + b_i, unsigned and zero-extended to WIDTH+1; sum wraps mod 2^WIDTH.
REQ-017 Accept condition: accept = (|req) & (~out_valid | out_ready).
REQ-018 gnt SHALL be combinational, asserted only in cycles where accept is high; there is no separate acknowledge cycle.
REQ-019 Round-robin: the winner is the first set req bit searching upward from ptr, wrapping from NREQ-1 to 0.
REQ-020 On accept with winner w, ptr SHALL become (w+1) mod NREQ; otherwise ptr SHALL hold its value.
REQ-021 On accept, the result register SHALL load sum, carry and id = w on the next rising edge, and out_valid SHALL become 1.
REQ-022 Latency: a result SHALL appear exactly 1 cycle after its grant.
REQ-023 Throughput: the block SHALL accept 1 operation per cycle while out_ready is held high.
REQ-024 Drain without refill: if out_valid & out_ready & ~accept, out_valid SHALL go to 0 next cycle.
REQ-025 Simultaneous drain and accept SHALL replace the result register contents; out_valid stays 1.
REQ-026 Backpressure: while out_valid & ~out_ready, gnt SHALL be 0 and out_sum, out_carry and out_id SHALL be held stable.
REQ-027 Requester protocol: a requester holds req and its operands stable until it sees gnt; the block never grants a deasserted req bit.
REQ-028 A requester deasserting req before its grant SHALL be treated as a withdrawal, with no error and no state change.
REQ-029 req = 0 SHALL leave ptr and the result register unchanged, except for a drain per REQ-024.
REQ-030 The block SHALL contain no combinational path from out_ready to out_sum, out_carry or out_id.

Reset
REQ-031 While reset is high, gnt SHALL be 0 regardless of req.
REQ-032 The edge after reset is high SHALL set out_valid=0, out_sum=0, out_carry=0, out_id=0 and ptr=0.
REQ-033 Reset mid-operation SHALL discard any pending result; no result is delivered for an operation granted in the same cycle reset is high.

Verification (WIDTH=8, NREQ=4)
REQ-034 Stimulus: req=0001, a0=10, b0=246 (-10), out_ready=1. Response: gnt=0001 the same cycle; next cycle out_valid=1, out_sum=0, out_carry=1, out_id=0.
REQ-035 Stimulus: req=0100, a2=65, b2=66. Response: gnt=0100; next cycle out_sum=131, out_carry=0, out_id=2.
REQ-036 Stimulus: req=1111 held, out_ready=1, starting from ptr=0. Response: gnt sequence 0001, 0010, 0100, 1000, 0001, with one result per cycle and out_id of 0,1,2,3,0.
REQ-037 Stimulus: out_valid=1, out_ready=0, req=0011 for 3 cycles. Response: gnt=0 and the output is stable throughout. Then out_ready=1: the same cycle grants the pending winner and the result is replaced on the next edge.
REQ-038 Stimulus: grant to requester 2, then req=1010. Response: gnt=1000 next (ptr=3), then gnt=0010.
REQ-039 Stimulus: reset=1 for 1 cycle while out_valid=1 and req=1111. Response: gnt=0 during reset; next cycle out_valid=0 and ptr=0; the first post-reset grant is 0001.
